// File: rtl/seg7_scan_reader.sv
// Read-back monitor for a scanned active-low 7-segment bus: debounces each scan slot and decodes it to hex.
// Optional per-digit refresh timeout is enabled by defining SEG7_SCAN_READER_TIMEOUT_EN.
module seg7_scan_reader #(
  parameter  int NDIG    = 8,
  parameter  int STABLE  = 4,
  parameter  int TIMEOUT = 1024,
  localparam int IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dvalid,
  output logic [NDIG-1:0]   derr,
  output logic [NDIG-1:0]   dp,
  output logic              upd,
  output logic [IDXW-1:0]   upd_idx
);
  localparam int CNTW = $clog2(STABLE + 1);
  localparam int INW  = NDIG + 8;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

  state_t            state_q;
  logic [INW-1:0]    samp_q;
  logic [CNTW-1:0]   cnt_q;
  logic [4*NDIG-1:0] digits_q;
  logic [NDIG-1:0]   dvalid_q;
  logic [NDIG-1:0]   derr_q;
  logic [NDIG-1:0]   dp_q;
  logic              upd_q;
  logic [IDXW-1:0]   upd_idx_q;

  logic [INW-1:0]    in_vec;
  logic              same;
  logic [NDIG-1:0]   sel_oh;
  logic              sel_ok;
  logic [IDXW-1:0]   sel_idx;
  logic              glyph_ok;
  logic [3:0]        glyph_val;
  logic              blank;
  logic              commit;
  logic [3:0]        cur_val;
  logic [3:0]        val_d;
  logic              err_d;
  logic              dp_d;
  logic              changed;
  logic              to_fire;
  logic [IDXW-1:0]   to_idx;

  if (STABLE < 2 || TIMEOUT < 2) begin : g_param_check
    $error("seg7_scan_reader: STABLE and TIMEOUT must both be at least 2");
  end

  assign in_vec = {an_n, seg_n};
  assign same   = (in_vec == samp_q);
  assign sel_oh = ~an_n;
  assign sel_ok = (sel_oh != '0) && ((sel_oh & (sel_oh - NDIG'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_oh[i]) sel_idx = IDXW'(i);
    end
  end

  // Match on a..g only; the decimal point is tracked separately.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case ({~seg_n[7:1], 1'b0})
      8'b1111_1100: glyph_val = 4'h0;
      8'b0110_0000: glyph_val = 4'h1;
      8'b1101_1010: glyph_val = 4'h2;
      8'b1111_0010: glyph_val = 4'h3;
      8'b0110_0110: glyph_val = 4'h4;
      8'b1011_0110: glyph_val = 4'h5;
      8'b1011_1110: glyph_val = 4'h6;
      8'b1110_0000: glyph_val = 4'h7;
      8'b1111_1110: glyph_val = 4'h8;
      8'b1111_0110: glyph_val = 4'h9;
      8'b1110_1110: glyph_val = 4'hA;
      8'b0011_1110: glyph_val = 4'hB;
      8'b1001_1100: glyph_val = 4'hC;
      8'b0111_1010: glyph_val = 4'hD;
      8'b1001_1110: glyph_val = 4'hE;
      8'b1000_1110: glyph_val = 4'hF;
      default:      glyph_ok  = 1'b0;
    endcase
  end

  assign blank   = (seg_n[7:1] == 7'h7F);
  assign commit  = (state_q == S_TRACK) && (cnt_q == CNTW'(STABLE - 1)) && same;
  assign cur_val = digits_q[{sel_idx, 2'b00} +: 4];
  assign val_d   = glyph_ok ? glyph_val : cur_val;
  assign err_d   = !glyph_ok && !blank;
  assign dp_d    = ~seg_n[0];
  assign changed = (val_d != cur_val) || (glyph_ok != dvalid_q[sel_idx]) ||
                   (err_d != derr_q[sel_idx]) || (dp_d != dp_q[sel_idx]);

`ifdef SEG7_SCAN_READER_TIMEOUT_EN
  localparam int AGEW = $clog2(TIMEOUT);
  logic [NDIG-1:0] age_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_age
      logic [AGEW-1:0] age_q;
      logic            own_commit;
      assign own_commit = commit && (sel_idx == IDXW'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          age_q <= '0;
        end else if (own_commit) begin
          age_q <= '0;
        end else if (age_q != AGEW'(TIMEOUT - 1)) begin
          age_q <= age_q + AGEW'(1);
        end
      end
      // Only an expiry that actually clears something is worth reporting.
      assign age_hit[gi] = (age_q == AGEW'(TIMEOUT - 1)) && (dvalid_q[gi] || dp_q[gi]) && !own_commit;
    end
  endgenerate

  always_comb begin
    to_idx = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (age_hit[i]) to_idx = IDXW'(i);
    end
  end
  assign to_fire = (age_hit != '0) && !(commit && changed);
`else
  assign to_fire = 1'b0;
  assign to_idx  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      samp_q    <= '1;
      cnt_q     <= '0;
      digits_q  <= '0;
      dvalid_q  <= '0;
      derr_q    <= '0;
      dp_q      <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      samp_q <= in_vec;
      if (!same || !sel_ok) begin
        cnt_q <= '0;
      end else if (cnt_q != CNTW'(STABLE)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end

      case (state_q)
        S_IDLE:  if (sel_ok) state_q <= S_TRACK;
        S_TRACK: begin
          if (!sel_ok)     state_q <= S_IDLE;
          else if (commit) state_q <= S_HOLD;
        end
        S_HOLD:  if (!same) state_q <= sel_ok ? S_TRACK : S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      upd_q <= 1'b0;
      if (commit) begin
        digits_q[{sel_idx, 2'b00} +: 4] <= val_d;
        dvalid_q[sel_idx]               <= glyph_ok;
        derr_q[sel_idx]                 <= err_d;
        dp_q[sel_idx]                   <= dp_d;
        if (changed) begin
          upd_q     <= 1'b1;
          upd_idx_q <= sel_idx;
        end
      end
      if (to_fire) begin
        dvalid_q[to_idx] <= 1'b0;
        dp_q[to_idx]     <= 1'b0;
        upd_q            <= 1'b1;
        upd_idx_q        <= to_idx;
      end
    end
  end

  assign digits  = digits_q;
  assign dvalid  = dvalid_q;
  assign derr    = derr_q;
  assign dp      = dp_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus random scans against a dwell-based model.
module tb_seg7_scan_reader;
  localparam int NDIG    = 8;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_n = 8'hFF;
  logic [7:0]  an_n  = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  dvalid, derr, dp;
  logic        upd;
  logic [2:0]  upd_idx;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .digits(digits), .dvalid(dvalid), .derr(derr), .dp(dp),
    .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Active-high a..g,dp patterns for hex 0..F.
  logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Reference model: a dwell commits once its input has been seen on STABLE+1 consecutive edges.
  logic [3:0]  m_val [8];
  logic [7:0]  m_valid = '0, m_err = '0, m_dp = '0;
  logic [15:0] m_prev = '1;
  int          m_run = 0;
  bit          m_done = 1'b0;
  int          m_since [8];
  int          exp_q[$];
  int          got_q[$];

  function automatic logic [55:0] model_vec();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = m_val[i];
    return {d, m_valid, m_err, m_dp};
  endfunction

  task automatic model_edge(input logic [7:0] an, input logic [7:0] seg);
    logic [15:0] cur;
    int sel, t;
    bit com, chg, gok, blank, nerr, ndp;
    logic [3:0] nv;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_val[i] = 4'h0; m_since[i] = 0; end
      m_valid = '0; m_err = '0; m_dp = '0;
      m_prev = '1; m_run = 0; m_done = 1'b0;
      return;
    end
    cur = {an, seg};
    if (cur == m_prev) m_run++;
    else begin m_run = 1; m_done = 1'b0; end
    m_prev = cur;
    com = 1'b0; chg = 1'b0; sel = -1;
    if ($countones(~an) == 1 && m_run == STABLE + 1 && !m_done) begin
      m_done = 1'b1; com = 1'b1;
      for (int i = 0; i < 8; i++) if (!an[i]) sel = i;
      gok = 1'b0; nv = m_val[sel];
      for (int v = 0; v < 16; v++) if (glyph[v][7:1] == ~seg[7:1]) begin gok = 1'b1; nv = v[3:0]; end
      blank = (seg[7:1] == 7'h7F);
      nerr = !gok && !blank;
      ndp = !seg[0];
      chg = (nv != m_val[sel]) || (gok != m_valid[sel]) || (nerr != m_err[sel]) || (ndp != m_dp[sel]);
      m_val[sel] = nv; m_valid[sel] = gok; m_err[sel] = nerr; m_dp[sel] = ndp;
      m_since[sel] = 0;
      if (chg) exp_q.push_back(cyc * 16 + sel);
    end
    for (int j = 0; j < 8; j++) if (!(com && j == sel) && m_since[j] < 1000000) m_since[j]++;
    t = -1;
`ifdef SEG7_SCAN_READER_TIMEOUT_EN
    if (!(com && chg))
      for (int j = 0; j < 8; j++)
        if (t < 0 && m_since[j] >= TIMEOUT && (m_valid[j] || m_dp[j]) && !(com && j == sel)) t = j;
    if (t >= 0) begin
      m_valid[t] = 1'b0; m_dp[t] = 1'b0;
      exp_q.push_back(cyc * 16 + t);
    end
`endif
  endtask

  task automatic step(input logic [7:0] an, input logic [7:0] seg);
    an_n = an; seg_n = seg;
    @(posedge clk);
    cyc++;
    model_edge(an, seg);
    #1;
    if (upd === 1'b1) got_q.push_back(cyc * 16 + int'(upd_idx));
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) step(an, seg);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) step(8'($urandom), 8'($urandom));
    tests_run++;
    if ({digits, dvalid, derr, dp, upd} !== 57'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h required 0", {digits, dvalid, derr, dp, upd});
    end
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    hold(8'hFF, 8'($urandom), 4);
    tests_run++;
    if (got_q.size() != 0) begin tests_failed++; $display("FAIL reset_no_upd: got %0d pulses required 0", got_q.size()); end
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL reset_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_glyph_decode();
    exp_q.delete(); got_q.delete();
    hold(8'hFE, ~8'b1101_1010, 4);
    tests_run++;
    if (dvalid[0] !== 1'b0 || upd !== 1'b0) begin
      tests_failed++; $display("FAIL decode_early: got dvalid0=%b upd=%b required 0 0", dvalid[0], upd);
    end
    step(8'hFE, ~8'b1101_1010);
    tests_run++;
    if (digits[3:0] !== 4'h2 || dvalid[0] !== 1'b1) begin
      tests_failed++; $display("FAIL decode_value: got %h/%b required 2/1", digits[3:0], dvalid[0]);
    end
    tests_run++;
    if (upd !== 1'b1 || upd_idx !== 3'd0) begin
      tests_failed++; $display("FAIL decode_upd: got upd=%b idx=%0d required 1 0", upd, upd_idx);
    end
    tests_run++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++; $display("FAIL decode_upd_count: got %0d required 1 (model %0d)", got_q.size(), exp_q.size());
    end
    exp_q.delete(); got_q.delete();
    hold(8'hFF, 8'hFF, 2);
    hold(8'hFE, ~8'b1101_1010, 6);
    tests_run++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL decode_repeat_upd: got %0d pulses required 0 (model %0d)", got_q.size(), exp_q.size());
    end
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL decode_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_glyph_decode done");
  endtask

  task automatic test_full_scan();
    exp_q.delete(); got_q.delete();
    for (int d = 0; d < 8; d++) hold(~(8'h01 << d), ~glyph[d + 8], 6);
`ifndef SEG7_SCAN_READER_TIMEOUT_EN
    tests_run++;
    if (digits !== 32'hFEDCBA98 || dvalid !== 8'hFF) begin
      tests_failed++; $display("FAIL scan_const: got %h/%h required fedcba98/ff", digits, dvalid);
    end
    tests_run++;
    if (got_q.size() != 8) begin tests_failed++; $display("FAIL scan_pulses: got %0d required 8", got_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (got_q[k] % 16 != k) begin tests_failed++; $display("FAIL scan_order_%0d: got idx %0d required %0d", k, got_q[k] % 16, k); end
    end
`endif
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL scan_upd_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else for (int k = 0; k < exp_q.size(); k++) begin
      tests_run++;
      if (got_q[k] != exp_q[k]) begin
        tests_failed++; $display("FAIL scan_upd_%0d: got cyc %0d idx %0d required cyc %0d idx %0d", k, got_q[k] / 16, got_q[k] % 16, exp_q[k] / 16, exp_q[k] % 16);
      end
    end
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL scan_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_full_scan done");
  endtask

  task automatic test_glitch_invalid();
    exp_q.delete(); got_q.delete();
    hold(8'hF7, ~glyph[7], 3);
    hold(8'hF0, ~glyph[1], 10);
    hold(8'hFB, ~glyph[5], 4);
    hold(8'hFF, 8'hFF, 3);
    tests_run++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL glitch_upd: got %0d pulses required 0 (model %0d)", got_q.size(), exp_q.size());
    end
`ifndef SEG7_SCAN_READER_TIMEOUT_EN
    tests_run++;
    if (digits !== 32'hFEDCBA98 || dvalid !== 8'hFF) begin
      tests_failed++; $display("FAIL glitch_hold: got %h/%h required fedcba98/ff", digits, dvalid);
    end
`endif
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL glitch_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_glitch_invalid done");
  endtask

  task automatic test_err_blank();
    hold(8'hDF, ~8'b0000_0010, 6);
    tests_run++;
    if (derr[5] !== 1'b1 || dvalid[5] !== 1'b0) begin
      tests_failed++; $display("FAIL dash: got derr=%b dvalid=%b required 1 0", derr[5], dvalid[5]);
    end
    hold(8'hDF, 8'hFF, 6);
    tests_run++;
    if (derr[5] !== 1'b0 || dvalid[5] !== 1'b0) begin
      tests_failed++; $display("FAIL blank: got derr=%b dvalid=%b required 0 0", derr[5], dvalid[5]);
    end
    hold(8'hDF, ~8'b1111_1101, 6);
    tests_run++;
    if (dvalid[5] !== 1'b1 || dp[5] !== 1'b1 || digits[23:20] !== 4'h0) begin
      tests_failed++; $display("FAIL zero_dp: got v=%b dp=%b val=%h required 1 1 0", dvalid[5], dp[5], digits[23:20]);
    end
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL errblank_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_err_blank done");
  endtask

  task automatic test_commit_edge_change();
    exp_q.delete(); got_q.delete();
    hold(8'hFB, ~glyph[3], 4);
    hold(8'hEF, ~glyph[3], 4);
    hold(8'hFF, 8'hFF, 2);
    tests_run++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL edge_change_upd: got %0d pulses required 0 (model %0d)", got_q.size(), exp_q.size());
    end
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL edge_change_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_commit_edge_change done");
  endtask

  task automatic test_random();
    logic [7:0] an, seg;
    int r;
    exp_q.delete(); got_q.delete();
    for (int d = 0; d < 300; d++) begin
      r = $urandom_range(0, 99);
      if (r < 80) an = ~(8'h01 << $urandom_range(0, 7));
      else an = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60) seg = ~(glyph[$urandom_range(0, 15)] | 8'($urandom_range(0, 1)));
      else if (r < 75) seg = {7'h7F, 1'($urandom_range(0, 1))};
      else seg = 8'($urandom);
      hold(an, seg, $urandom_range(1, 7));
      if (d % 25 == 24) begin
        tests_run++;
        if ({digits, dvalid, derr, dp} !== model_vec()) begin
          tests_failed++; $display("FAIL random_state_%0d: got %h required %h", d, {digits, dvalid, derr, dp}, model_vec());
        end
      end
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_upd_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else for (int k = 0; k < exp_q.size(); k++) begin
      tests_run++;
      if (got_q[k] != exp_q[k]) begin
        tests_failed++; $display("FAIL random_upd_%0d: got cyc %0d idx %0d required cyc %0d idx %0d", k, got_q[k] / 16, got_q[k] % 16, exp_q[k] / 16, exp_q[k] % 16);
      end
    end
    $display("[TB] test_random done, %0d updates", exp_q.size());
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    step(8'hFF, 8'hFF);
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    hold(8'hFD, ~glyph[4], 5);
    tests_run++;
    if (dvalid[1] !== 1'b1 || digits[7:4] !== 4'h4) begin
      tests_failed++; $display("FAIL timeout_commit: got %b/%h required 1/4", dvalid[1], digits[7:4]);
    end
    got_q.delete(); exp_q.delete();
`ifdef SEG7_SCAN_READER_TIMEOUT_EN
    hold(8'hFF, 8'hFF, 15);
    tests_run++;
    if (dvalid[1] !== 1'b1 || got_q.size() != 0) begin
      tests_failed++; $display("FAIL timeout_early: got dvalid=%b pulses=%0d required 1 0", dvalid[1], got_q.size());
    end
    step(8'hFF, 8'hFF);
    tests_run++;
    if (dvalid[1] !== 1'b0) begin tests_failed++; $display("FAIL timeout_clear: got %b required 0", dvalid[1]); end
    tests_run++;
    if (upd !== 1'b1 || upd_idx !== 3'd1) begin
      tests_failed++; $display("FAIL timeout_upd: got upd=%b idx=%0d required 1 1", upd, upd_idx);
    end
`else
    hold(8'hFF, 8'hFF, 40);
    tests_run++;
    if (dvalid[1] !== 1'b1 || got_q.size() != 0) begin
      tests_failed++; $display("FAIL persist: got dvalid=%b pulses=%0d required 1 0", dvalid[1], got_q.size());
    end
`endif
    tests_run++;
    if ({digits, dvalid, derr, dp} !== model_vec()) begin
      tests_failed++; $display("FAIL timeout_state: got %h required %h", {digits, dvalid, derr, dp}, model_vec());
    end
    $display("[TB] test_timeout done");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_val[i] = 4'h0; m_since[i] = 0; end
    test_reset();
    test_glyph_decode();
    test_full_scan();
    test_glitch_invalid();
    test_err_blank();
    test_commit_edge_change();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Read-back monitor for a scanned, active-low 7-segment display bus: the receiving end of the hex-to-segment path. Samples the segment lines and digit-select lines, waits for each digit's pattern to settle, and decodes it back into a 4-bit hex value per digit. Used by self-checking display tests and by the debug console to report what the display actually shows.

## Interface

**Parameters**
- `NDIG`, default 8: number of scanned digits.
- `STABLE`, default 4: cycles a pattern must hold before it is committed; must be ≥ 2.
- `TIMEOUT`, default 1024: refresh timeout in cycles; used only with the configuration macro.

**Ports** (clock and reset first)
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst` input, 1: synchronous reset, active-high.
- `seg_n` input, 8: active-low segments. Bit 7..1 = a,b,c,d,e,f,g; bit 0 = dp.
- `an_n` input, NDIG: active-low digit selects; exactly one is low for a valid scan slot.
- `digits` output, 4*NDIG: decoded value; digit i is in `digits[4i+3:4i]`.
- `dvalid` output, NDIG: the digit holds a recognized hex glyph.
- `derr` output, NDIG: the last committed pattern was unrecognized.
- `dp` output, NDIG: committed decimal-point state, 1 = lit.
- `upd` output, 1: one-cycle pulse when any digit's committed state changes.
- `upd_idx` output, clog2(NDIG): index of the digit that changed; valid while `upd` = 1.

## Operation

**Glyphs.** Active-high patterns, bits a..g then dp = 0. The decoder inverts `seg_n` before matching, and dp is ignored for matching.
- 0–9: 1111_1100, 0110_0000, 1101_1010, 1111_0010, 0110_0110, 1011_0110, 1011_1110, 1110_0000, 1111_1110, 1111_0110.
- A–F: 1110_1110, 0011_1110, 1001_1100, 0111_1010, 1001_1110, 1000_1110.

**Sample stage.** `{an_n, seg_n}` is registered every cycle into `samp`.

**Stability counter `cnt`.** Width clog2(STABLE+1).
- Resets to 0 when the input differs from `samp`, or when `an_n` is not one-hot-low.
- Otherwise increments and saturates at STABLE.

**State machine.**
- IDLE: no valid select. Goes to TRACK when `an_n` is one-hot-low.
- TRACK: counting. Goes to HOLD on commit. Returns to IDLE when the select becomes invalid. Stays in TRACK with `cnt` = 0 on any other input change.
- HOLD: committed. Leaves on any input change, to TRACK if the new select is valid, otherwise to IDLE.

**Commit.** Occurs in TRACK when `cnt` == STABLE−1 and the input still equals `samp`. Exactly one commit per dwell. For the selected digit i:
- Recognized glyph: `digits`[i] = value, `dvalid`[i] = 1, `derr`[i] = 0.
- All segments off (blank): `dvalid`[i] = 0, `derr`[i] = 0, `digits`[i] unchanged.
- Any other pattern, including the dash 0000_0010: `dvalid`[i] = 0, `derr`[i] = 1, `digits`[i] unchanged.
- `dp`[i] = ~`seg_n`[0].

**Update pulse.** `upd` = 1 and `upd_idx` = i on the cycle after a commit edge, only if any of `digits`/`dvalid`/`derr`/`dp` for digit i changed.

## Timing

- **Reset.** While `rst` is high at a rising edge: all outputs 0, `samp` = all-ones, `cnt` = 0, state IDLE. Reset mid-dwell discards the partial count.
- **Commit latency.** An input held from capture edge k commits at edge k+STABLE, which is STABLE+1 rising edges counting the capture edge. `digits`/`dvalid`/`derr`/`dp` and `upd` become visible after that edge.
- **Multiple selects low, or none low.** No commit. Previously committed values are held.
- **Glitch shorter than STABLE cycles.** No commit, no `upd`.
- **Same digit re-presented with an identical pattern.** A commit occurs but `upd` stays 0.
- **Digit select changes on the commit edge.** The commit does not occur, because the input must still match `samp` on that edge.
- **Outputs are registered.** There is no combinational path from the inputs to the outputs.

## Configuration

- **`SEG7_SCAN_READER_TIMEOUT_EN` defined.** Each digit has its own age counter, width clog2(TIMEOUT).
  - A commit to digit i clears its counter.
  - Otherwise the counter increments and saturates.
  - When it reaches TIMEOUT−1, `dvalid`[i] and `dp`[i] clear and `upd` pulses with `upd_idx` = i, unless a commit-driven `upd` fires that cycle, in which case the commit-driven pulse wins and the timeout is re-evaluated next cycle.
  - Reset clears all age counters.
- **Macro undefined.** No age counters. Committed state persists indefinitely. The `TIMEOUT` parameter is ignored.

## Test plan

All scenarios use NDIG = 8 and STABLE = 4 unless stated.

- **Reset.** Assert `rst` for 2 cycles with arbitrary inputs → all outputs 0, and no `upd` for the 4 cycles after release with `an_n` = 8'hFF.
- **Glyph decode.** `an_n` = 8'hFE, `seg_n` = ~8'b1101_1010 held → after 5 edges, `digits[3:0]` = 2, `dvalid[0]` = 1, one `upd` pulse with `upd_idx` = 0. Re-present the same pattern → no `upd`.
- **Full scan.** Scan digits 0..7 with values 8,9,A,b,C,d,E,F, 6 cycles each → `digits` = 32'hFEDCBA98, `dvalid` = 8'hFF, 8 `upd` pulses with idx 0..7 in order.
- **Glitch and invalid select.** Select digit 3 with glyph 7 for 3 cycles → no commit. Set `an_n` = 8'hF0 for 10 cycles → no commit, prior state held.
- **Error and blank.** Digit 5 with dash ~8'b0000_0010 → `derr[5]` = 1, `dvalid[5]` = 0. Then blank 8'hFF → `derr[5]` = 0, `dvalid[5]` = 0. Then ~8'b1111_1101 (glyph 0, dp lit) → `dvalid[5]` = 1, `dp[5]` = 1, value 0.
- **Timeout (`SEG7_SCAN_READER_TIMEOUT_EN`, TIMEOUT = 16).** Commit digit 1 = 4, then hold `an_n` = 8'hFF → 16 cycles after the commit, `dvalid[1]` = 0 and `upd` pulses with `upd_idx` = 1.
